rom_scan_arbiter: RTL and testbench
===================================

// Module: rom_scan_arbiter
// PURPOSE
//  Shares one synchronous coefficient ROM between N_REQ requesters; each request scans a ROM range for its max value/index.
//  Round-robin arbitration, one scan at a time; result returned on a valid/ready response channel tagged with requester id.
//  Sits between the ROM macro (1-cycle read latency) and the client blocks that previously each held a private scanner.
// PARAMETERS
//  DATA_W  16  ROM word width
//  ADDR_W  8   ROM address width (depth 2**ADDR_W)
//  N_REQ   2   number of requesters (2..4)
// PORTS
//  clk         in   1               system clock
//  rst         in   1               synchronous reset, active-high
//  req_valid   in   N_REQ           per-requester request valid
//  req_ready   out  N_REQ           one-hot accept pulse (1 cycle)
//  req_start   in   N_REQ*ADDR_W    per-requester start address
//  req_len     in   N_REQ*(ADDR_W+1) per-requester word count, 0..2**ADDR_W
//  req_mode    in   N_REQ           0=max, 1=min (used only with macro)
//  rom_rd_en   out  1               ROM read strobe
//  rom_addr    out  ADDR_W          ROM read address
//  rom_rdata   in   DATA_W          ROM data, valid 1 cycle after rom_rd_en
//  rsp_valid   out  1               result valid, held until rsp_ready
//  rsp_ready   in   1               result consumed
//  rsp_id      out  clog2(N_REQ)    requester that owns the result
//  rsp_value   out  DATA_W          extreme value found
//  rsp_index   out  ADDR_W          address of that value
// BEHAVIOUR
//  - Reset: req_ready=0, rom_rd_en=0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_value=0, rsp_index=0, rr pointer=0, state IDLE.
//  - States IDLE -> SCAN -> DRAIN -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant first valid at/after rr pointer; assert that req_ready bit this cycle; latch start/len/mode/id.
//  - Requester must hold valid+fields until its req_ready; dropping valid before grant withdraws the request.
//  - SCAN: rom_rd_en=1 each cycle, rom_addr = start + k (k=0..len-1), modulo 2**ADDR_W (wrap-around legal).
//  - Compare on returned data: first word initialises best; later words replace only if strictly greater (min: strictly less)
//    -> ties keep lowest scan position (first occurrence, in wrapped order).
//  - DRAIN: one cycle for the last word's return, rom_rd_en=0.
//  - RESP: rsp_valid=1, outputs stable until rsp_ready; on handshake -> IDLE, rr pointer = granted id + 1 (mod N_REQ).
//  - Latency: accept cycle T -> rsp_valid first high at T+len+2.
//  - len=0: no ROM reads, skip to RESP next cycle; rsp_value=0, rsp_index=start.
//  - No new request accepted outside IDLE; rsp_ready ignored when rsp_valid=0.
//  - rst mid-scan/mid-RESP: scan abandoned, no response emitted, all state to reset values.
// CONFIGURATION
//  ROM_SCAN_ARGMIN_EN defined: req_mode honoured per request (1 = min search).
//  Not defined: req_mode ignored, every scan is max; compare logic for min not built.
// STRUCTURE
//  Package rom_scan_pkg: state enum (IDLE/SCAN/DRAIN/RESP), DATA_W/ADDR_W defaults, mode constants MODE_MAX/MODE_MIN.
//  Sub-module rom_scan_cmp: best-value/index register + strict compare, init on first word; arbiter/FSM stays in top.
// TESTING  (bench ROM: rom[a]=a, except where noted)
//  - rom[0x10]=0xBEEF; req0 start=0x00 len=32 -> rsp id=0 value=0xBEEF index=0x10, rsp_valid at accept+34.
//  - req0,req1 valid same cycle after reset -> req0 served first, then req1; repeat -> req1 first (rr pointer moved).
//  - req1 start=0xF8 len=16 -> reads F8..FF,00..07; rsp value=0x00FF index=0xFF.
//  - rom[3]=rom[5]=0x7777 (others <), start=0 len=8 -> index=3; len=0 start=0x42 -> value=0 index=0x42 at accept+2.
//  - rsp_ready low 10 cycles -> rsp fields stable, req_ready stays 0 despite pending req; rst pulse mid-SCAN -> no rsp, next req normal.
//  - With ROM_SCAN_ARGMIN_EN, rom[0x20]=0x0000, others >=1, start=0x18 len=16 mode=1 -> value=0 index=0x20.

Source files
------------

// File: rtl/rom_scan_pkg.sv
// Shared types and constants for the ROM scan arbiter.
//   state_e       : arbiter FSM states (IDLE -> SCAN -> DRAIN -> RESP)
//   DATA_W_DEF    : default ROM word width
//   ADDR_W_DEF    : default ROM address width
//   MODE_MAX/MIN  : req_mode encodings (min only honoured with ROM_SCAN_ARGMIN_EN)
package rom_scan_pkg;
  localparam int   DATA_W_DEF = 16;
  localparam int   ADDR_W_DEF = 8;
  localparam logic MODE_MAX   = 1'b0;
  localparam logic MODE_MIN   = 1'b1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, RESP} state_e;
endpackage

// File: rtl/rom_scan_cmp.sv
// Best-value tracker for one ROM scan.
//   clk, rst    : clock, synchronous active-high reset
//   init_i      : start of a new scan; best cleared to 0, index preset to start address
//   init_idx_i  : start address (reported index when the scan reads nothing)
//   mode_i      : MODE_MAX / MODE_MIN (port exists only with ROM_SCAN_ARGMIN_EN)
//   en_i        : data_i/idx_i carry a returned ROM word
//   best_o      : current extreme value
//   best_idx_o  : address of that value
// Macro ROM_SCAN_ARGMIN_EN adds the min comparator; without it only max is built.
module rom_scan_cmp
  import rom_scan_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_i,
  input  logic [ADDR_W-1:0] init_idx_i,
`ifdef ROM_SCAN_ARGMIN_EN
  input  logic              mode_i,
`endif
  input  logic              en_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] idx_i,
  output logic [DATA_W-1:0] best_o,
  output logic [ADDR_W-1:0] best_idx_o
);
  logic              have_q;
  logic [DATA_W-1:0] best_q;
  logic [ADDR_W-1:0] idx_q;
  logic              better;

  // Strict compare: equal values never replace, so the first occurrence wins.
`ifdef ROM_SCAN_ARGMIN_EN
  assign better = (mode_i == MODE_MIN) ? (data_i < best_q) : (data_i > best_q);
`else
  assign better = data_i > best_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      have_q <= 1'b0;
      best_q <= '0;
      idx_q  <= '0;
    end else if (init_i) begin
      have_q <= 1'b0;
      best_q <= '0;
      idx_q  <= init_idx_i;
    end else if (en_i && (!have_q || better)) begin
      have_q <= 1'b1;
      best_q <= data_i;
      idx_q  <= idx_i;
    end
  end

  assign best_o     = best_q;
  assign best_idx_o = idx_q;
endmodule

// File: rtl/rom_scan_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM between N_REQ scanners.
// Each accepted request reads len words from start (wrapping) and returns the
// max (or min) value and its address on a valid/ready response channel.
//   clk, rst          : clock, synchronous active-high reset
//   req_valid/ready   : per-requester request; req_ready is a 1-cycle accept pulse
//   req_start/len/mode: per-requester scan range and search mode
//   rom_rd_en/addr    : ROM read port, rom_rdata returns one cycle later
//   rsp_valid/ready   : result handshake; rsp_id/value/index held until taken
// Macro ROM_SCAN_ARGMIN_EN: honour req_mode (1 = min search); otherwise always max.
module rom_scan_arbiter
  import rom_scan_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int N_REQ  = 2,
  localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int LEN_W  = ADDR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_valid,
  output logic [N_REQ-1:0]             req_ready,
  input  logic [N_REQ-1:0][ADDR_W-1:0] req_start,
  input  logic [N_REQ-1:0][LEN_W-1:0]  req_len,
  input  logic [N_REQ-1:0]             req_mode,
  output logic                         rom_rd_en,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic [DATA_W-1:0]            rom_rdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_W-1:0]            rsp_value,
  output logic [ADDR_W-1:0]            rsp_index
);
  state_e            state_q;
  logic [ID_W-1:0]   rr_q, id_q, gnt_id;
  logic              gnt_vld, accept;
  logic [LEN_W-1:0]  cnt_q;        // reads still to issue, including current
  logic              rd_en_q, rd_vld_q, rsp_valid_q;
  logic [ADDR_W-1:0] addr_q, rd_idx_q;
`ifdef ROM_SCAN_ARGMIN_EN
  logic              mode_q;
`else
  logic              unused_mode;
  assign unused_mode = ^req_mode;
`endif

  // First valid requester at or after the round-robin pointer.
  always_comb begin
    int j;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    j       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = (int'(rr_q) + k) % N_REQ;
      if (!gnt_vld && req_valid[j]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(j);
      end
    end
  end

  // Accept is same-cycle so the requester sees req_ready while still holding
  // its fields; gating with rst keeps it low during reset.
  assign accept = (state_q == IDLE) && gnt_vld && !rst;

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      req_ready[i] = accept && (gnt_id == ID_W'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ROM_SCAN_ARGMIN_EN
      mode_q      <= MODE_MAX;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          id_q    <= gnt_id;
          cnt_q   <= req_len[gnt_id];
          addr_q  <= req_start[gnt_id];
          rd_en_q <= (req_len[gnt_id] != '0);
`ifdef ROM_SCAN_ARGMIN_EN
          mode_q  <= req_mode[gnt_id];
`endif
          state_q <= SCAN;
        end
        SCAN: begin
          if (cnt_q == '0) begin
            // len=0: nothing read, report straight away
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q == LEN_W'(1)) begin
            rd_en_q <= 1'b0;
            state_q <= DRAIN;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);   // natural wrap at 2**ADDR_W
            cnt_q  <= cnt_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          rr_q        <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ROM data arrives one cycle after the strobe; align the address with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      rd_vld_q <= rd_en_q;
      rd_idx_q <= addr_q;
    end
  end

  rom_scan_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .init_i     (accept),
    .init_idx_i (req_start[gnt_id]),
`ifdef ROM_SCAN_ARGMIN_EN
    .mode_i     (mode_q),
`endif
    .en_i       (rd_vld_q),
    .data_i     (rom_rdata),
    .idx_i      (rd_idx_q),
    .best_o     (rsp_value),
    .best_idx_o (rsp_index)
  );

  assign rom_rd_en = rd_en_q;
  assign rom_addr  = addr_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
endmodule

// File: tb/tb_rom_scan_arbiter.sv
// Bench for rom_scan_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase checked against a scan model.
module tb_rom_scan_arbiter;
  localparam int DW = 16, AW = 8, NR = 2, IW = 1;

  logic                     clk = 1'b0, rst = 1'b1;
  logic [NR-1:0]            req_valid = '0, req_ready, req_mode = '0;
  logic [NR-1:0][AW-1:0]    req_start = '0;
  logic [NR-1:0][AW:0]      req_len = '0;
  logic                     rom_rd_en;
  logic [AW-1:0]            rom_addr;
  logic [DW-1:0]            rom_rdata = '0;
  logic                     rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0]            rsp_id;
  logic [DW-1:0]            rsp_value;
  logic [AW-1:0]            rsp_index;

  logic [DW-1:0] rom [256];
  logic [AW-1:0] rd_q [$];
  int cyc = 0, total = 0, bad = 0, rr_m = 0;
  int f_st [NR], f_ln [NR], f_md [NR];

  rom_scan_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_start(req_start), .req_len(req_len), .req_mode(req_mode),
    .rom_rd_en(rom_rd_en), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_value(rsp_value), .rsp_index(rsp_index));

  always #5 clk = ~clk;

  // Synchronous ROM model plus a log of every read address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rom_rd_en) begin
      rom_rdata <= rom[rom_addr];
      rd_q.push_back(rom_addr);
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, exp);
    end
  endtask

  task automatic abort(input string nm);
    total++; bad++;
    $display("FAIL %s timeout", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic rom_init();
    for (int a = 0; a < 256; a++) rom[a] = 16'(a);
  endtask

  // Reference: walk the range in wrapped order, keep first strict extreme.
  function automatic void model(input int st, input int ln, input int md, output int v, output int idx);
    int m = md;
`ifndef ROM_SCAN_ARGMIN_EN
    m = 0;
`endif
    v = 0; idx = st;
    for (int k = 0; k < ln; k++) begin
      int a = (st + k) % 256;
      int d = int'(rom[a]);
      if (k == 0 || (m == 0 && d > v) || (m == 1 && d < v)) begin v = d; idx = a; end
    end
  endfunction

  task automatic start_req(input int id, input int st, input int ln, input int md);
    f_st[id] = st; f_ln[id] = ln; f_md[id] = md;
    req_start[id] = AW'(st);
    req_len[id]   = (AW+1)'(ln);
    req_mode[id]  = md[0];
    req_valid[id] = 1'b1;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NR; k++)
      if (req_valid[(rr_m + k) % NR]) return (rr_m + k) % NR;
    return -1;
  endfunction

  // Called at a negedge; returns at the accept cycle (t = cycle stamp).
  task automatic wait_any(output int gid, output int t);
    gid = -1; t = -1;
    for (int i = 0; i < 1000; i++) begin
      #1;
      if (req_ready != '0) begin
        t = cyc;
        chk("gnt_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int k = 0; k < NR; k++) if (req_ready[k]) gid = k;
        return;
      end
      @(negedge clk);
    end
    abort("grant");
  endtask

  task automatic finish_rsp(input int hold, input string nm);
    logic [DW-1:0] v0; logic [AW-1:0] i0; logic [IW-1:0] d0; bit st;
    v0 = rsp_value; i0 = rsp_index; d0 = rsp_id; st = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_value !== v0 || rsp_index !== i0 ||
          rsp_id !== d0 || req_ready !== '0) st = 1'b0;
    end
    if (hold > 0) chk({nm, "_stable"}, 32'(st), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_rsp_clr"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic complete(input int gid, input int t0, input int hold, input string nm,
                          input int ev, input int ei);
    int lat; bit aok;
    rd_q.delete();
    @(negedge clk);
    req_valid[gid] = 1'b0;
    lat = -1;
    for (int i = 0; i < 1000 && lat < 0; i++) begin
      if (rsp_valid) lat = cyc - t0;
      else @(negedge clk);
    end
    if (lat < 0) abort({nm, "_rsp"});
    chk({nm, "_lat"},   32'(lat),       32'(f_ln[gid] + 2));
    chk({nm, "_id"},    32'(rsp_id),    32'(gid));
    chk({nm, "_value"}, 32'(rsp_value), 32'(ev));
    chk({nm, "_index"}, 32'(rsp_index), 32'(ei));
    aok = (rd_q.size() == f_ln[gid]);
    foreach (rd_q[k]) if (int'(rd_q[k]) != (f_st[gid] + k) % 256) aok = 1'b0;
    chk({nm, "_reads"}, 32'(aok), 32'd1);
    finish_rsp(hold, nm);
    rr_m = (gid + 1) % NR;
  endtask

  // Serve the next grant and check it against the model.
  task automatic serve(input int exp_id, input int hold, input string nm);
    int g, t, ev, ei;
    wait_any(g, t);
    chk({nm, "_gnt"}, 32'(g), 32'(exp_id));
    model(f_st[g], f_ln[g], f_md[g], ev, ei);
    complete(g, t, hold, nm, ev, ei);
  endtask

  typedef struct {
    int id, st, ln, md, pa, pv, pb, pw, ev, ei;
  } vec_t;
  vec_t tv [9];

  initial begin
    int g, t;
    bit quiet;
    rom_init();
    tv[0] = '{0, 8'h00, 32,  0, 8'h10, 16'hBEEF, -1, 0,  16'hBEEF, 8'h10};
    tv[1] = '{1, 8'hF8, 16,  0, -1, 0, -1, 0,             16'h00FF, 8'hFF};
    tv[2] = '{0, 8'h00, 8,   0, 3, 16'h7777, 5, 16'h7777, 16'h7777, 8'h03};
    tv[3] = '{1, 8'h42, 0,   0, -1, 0, -1, 0,             16'h0000, 8'h42};
    tv[4] = '{0, 8'h80, 1,   0, -1, 0, -1, 0,             16'h0080, 8'h80};
    tv[5] = '{1, 8'h00, 256, 0, 8'h05, 16'hFFFF, 8'hF0, 16'hFFFF, 16'hFFFF, 8'h05};
    tv[6] = '{0, 8'hFE, 4,   0, 8'h01, 16'h00FF, -1, 0,   16'h00FF, 8'hFF};
`ifdef ROM_SCAN_ARGMIN_EN
    tv[7] = '{1, 8'h10, 3,   1, -1, 0, -1, 0,             16'h0010, 8'h10};
    tv[8] = '{0, 8'h18, 16,  1, 8'h20, 0, -1, 0,          16'h0000, 8'h20};
`else
    tv[7] = '{1, 8'h10, 3,   1, -1, 0, -1, 0,             16'h0012, 8'h12};
    tv[8] = '{0, 8'h18, 16,  1, 8'h20, 0, -1, 0,          16'h0027, 8'h27};
`endif

    // Reset state, with requests pending that must not be accepted.
    req_valid = '1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rd_en",     32'(rom_rd_en), 32'd0);
    chk("rst_addr",      32'(rom_addr),  32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id",    32'(rsp_id),    32'd0);
    chk("rst_rsp_value", 32'(rsp_value), 32'd0);
    chk("rst_rsp_index", 32'(rsp_index), 32'd0);
    req_valid = '0;
    rst = 1'b0;
    rr_m = 0;
    @(negedge clk);

    // Round robin: simultaneous after reset -> 0 then 1; after 0 alone -> 1 first.
    start_req(0, 8'h00, 4, 0); start_req(1, 8'h10, 4, 0);
    serve(0, 0, "rrA0");
    serve(1, 0, "rrA1");
    start_req(0, 8'h20, 2, 0);
    serve(0, 0, "rrB0");
    start_req(0, 8'h30, 3, 0); start_req(1, 8'h40, 3, 0);
    serve(1, 0, "rrB1");
    serve(0, 0, "rrB2");

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      rom_init();
      if (tv[i].pa >= 0) rom[tv[i].pa] = 16'(tv[i].pv);
      if (tv[i].pb >= 0) rom[tv[i].pb] = 16'(tv[i].pw);
      start_req(tv[i].id, tv[i].st, tv[i].ln, tv[i].md);
      wait_any(g, t);
      chk($sformatf("tv%0d_gnt", i), 32'(g), 32'(tv[i].id));
      complete(g, t, 0, $sformatf("tv%0d", i), tv[i].ev, tv[i].ei);
    end
    rom_init();

    // Back-pressure: result held 10 cycles while the other requester waits.
    start_req(0, 8'h60, 6, 0); start_req(1, 8'h70, 5, 0);
    serve(exp_grant(), 10, "hold");
    serve(exp_grant(), 0, "hold_next");

    // Reset pulse mid-scan: scan dropped, no response, pointer back to 0.
    start_req(1, 8'h00, 32, 0);
    wait_any(g, t);
    chk("rs_gnt", 32'(g), 32'd1);
    @(negedge clk); req_valid[1] = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rs_rd_en", 32'(rom_rd_en), 32'd0);
    chk("rs_addr",  32'(rom_addr),  32'd0);
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid || rom_rd_en) quiet = 1'b0;
    end
    chk("rs_quiet", 32'(quiet), 32'd1);
    rr_m = 0;
    start_req(0, 8'h50, 4, 0); start_req(1, 8'h58, 4, 0);
    serve(0, 0, "rs_post0");
    serve(1, 0, "rs_post1");

    // Randomized: random ROM, random pending sets, random back-pressure.
    for (int a = 0; a < 256; a++) rom[a] = 16'($urandom_range(0, 15));
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NR; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          start_req(i, $urandom_range(0, 255), $urandom_range(0, 40), $urandom_range(0, 1));
      if (req_valid == '0) begin
        g = $urandom_range(0, NR - 1);
        start_req(g, $urandom_range(0, 255), $urandom_range(0, 40), $urandom_range(0, 1));
      end
      serve(exp_grant(), $urandom_range(0, 3), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
